// File: rtl/uart_frame_rx.sv
// uart_frame_rx
// Deframer for payloads framed as &&payload&& on a byte stream from uart_rx.
// A lone '&' inside a payload is data; only "&&" closes a frame. Good frames
// are published as a flat byte vector plus length with a one-cycle done
// pulse. Overflow, inter-byte timeout and empty frames are dropped with a
// one-cycle error pulse and a held error code.
//
// Ports:
//   sys_clk, sys_rst_n   clock, synchronous active-low reset
//   uart_rx_data/_vld    incoming byte and its one-cycle strobe
//   rx_string            last good payload, byte k at [8k+7:8k], unused bytes 0
//   rx_length            byte count of last good payload
//   rx_done              one-cycle pulse, new payload published
//   rx_busy              high while the deframer is not idle
//   rx_err, rx_err_code  one-cycle drop pulse; code 1 ovf, 2 timeout, 3 empty
module uart_frame_rx #(
  parameter int MAX_LEN     = 137,
  parameter int TIMEOUT_CLK = 1_000_000
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [7:0]             uart_rx_data,
  input  logic                   uart_rx_vld,
  output logic [8*MAX_LEN-1:0]   rx_string,
  output logic [7:0]             rx_length,
  output logic                   rx_done,
  output logic                   rx_busy,
  output logic                   rx_err,
  output logic [1:0]             rx_err_code
);

  localparam logic [7:0] DELIM     = 8'h26;
  localparam int         TW        = $clog2(TIMEOUT_CLK + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLK - 1);
  localparam logic [7:0] LEN_MAX   = 8'(MAX_LEN);
  localparam logic [7:0] LEN_MAX2  = 8'(MAX_LEN - 2);

  localparam logic [1:0] ERR_OVF   = 2'd1;
  localparam logic [1:0] ERR_TO    = 2'd2;
  localparam logic [1:0] ERR_EMPTY = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOF,
    S_PAYLOAD,
    S_AMP,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [MAX_LEN-1:0][7:0]  buf_q, buf_d;
  logic [MAX_LEN-1:0][7:0]  str_q, str_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [7:0]               len_q, len_d;
  logic [TW-1:0]            to_q, to_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;
  logic                     err_q, err_d;
  logic [1:0]               code_q, code_d;

  logic is_delim;
  logic in_frame;
  logic timeout;

  assign is_delim = (uart_rx_data == DELIM);
  assign in_frame = (state_q == S_SOF) || (state_q == S_PAYLOAD) || (state_q == S_AMP);
  // A strobe on the expiring cycle wins over the timeout.
  assign timeout  = in_frame && !uart_rx_vld && (to_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    str_d   = str_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;

    if (uart_rx_vld || !in_frame) to_d = '0;
    else                          to_d = to_q + 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) begin
          str_d  = buf_q;
          len_d  = cnt_q;
          done_d = 1'b1;
        end
        // A byte landing in the DONE cycle is treated as if idle.
        if (uart_rx_vld && is_delim) state_d = S_SOF;
        else                         state_d = S_IDLE;
      end
      S_SOF: begin
        if (uart_rx_vld) begin
          if (is_delim) begin
            state_d = S_PAYLOAD;
            buf_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_PAYLOAD: begin
        if (uart_rx_vld) begin
          if (is_delim) begin
            state_d = S_AMP;
          end else if (cnt_q < LEN_MAX) begin
            for (int k = 0; k < MAX_LEN; k++)
              if (8'(k) == cnt_q) buf_d[k] = uart_rx_data;
            cnt_d = cnt_q + 8'd1;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_OVF;
          end
        end
      end
      S_AMP: begin
        if (uart_rx_vld) begin
          if (is_delim) begin
            if (cnt_q == 8'd0) begin
              state_d = S_IDLE;
              err_d   = 1'b1;
              code_d  = ERR_EMPTY;
            end else begin
              state_d = S_DONE;
            end
          end else if (cnt_q <= LEN_MAX2) begin
            // Held-back '&' turned out to be data: write it and this byte.
            for (int k = 0; k < MAX_LEN; k++) begin
              if (8'(k) == cnt_q)         buf_d[k] = DELIM;
              if (8'(k) == cnt_q + 8'd1)  buf_d[k] = uart_rx_data;
            end
            cnt_d   = cnt_q + 8'd2;
            state_d = S_PAYLOAD;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_OVF;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      code_d  = ERR_TO;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      str_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      to_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      str_q   <= str_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      to_q    <= to_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign rx_string   = str_q;
  assign rx_length   = len_q;
  assign rx_done     = done_q;
  assign rx_busy     = busy_q;
  assign rx_err      = err_q;
  assign rx_err_code = code_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Testbench for uart_frame_rx: directed frames from the test plan plus a
// randomized byte stream. A byte-level reference model predicts every done
// and error event (with its edge) into a scoreboard; a negedge monitor pops
// and compares whenever the DUT pulses rx_done or rx_err.
module tb_uart_frame_rx;
  localparam int ML = 4;
  localparam int TO = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        data;
  logic              vld;
  logic [8*ML-1:0]   rx_string;
  logic [7:0]        rx_length;
  logic              rx_done, rx_busy, rx_err;
  logic [1:0]        rx_err_code;

  uart_frame_rx #(.MAX_LEN(ML), .TIMEOUT_CLK(TO)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .uart_rx_data(data), .uart_rx_vld(vld),
    .rx_string(rx_string), .rx_length(rx_length), .rx_done(rx_done),
    .rx_busy(rx_busy), .rx_err(rx_err), .rx_err_code(rx_err_code)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_chk = 0;
  int n_err = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endfunction

  typedef struct {
    bit              is_done;
    logic [1:0]      code;
    logic [7:0]      len;
    logic [8*ML-1:0] str;
    int              at_edge;
  } exp_t;
  exp_t sb[$];

  // Reference model: payload as a byte queue, frame position as a small
  // mode, timeout as an edge-count gap between bytes.
  int              mode;   // 0 outside frame, 1 after first '&', 2 in payload, 3 '&' pending
  logic [7:0]      pl[$];
  int              last_e;
  logic [8*ML-1:0] good_str;
  logic [7:0]      good_len;

  function automatic void push_err(logic [1:0] code, int e);
    exp_t x;
    x.is_done = 1'b0; x.code = code; x.len = good_len; x.str = good_str; x.at_edge = e;
    sb.push_back(x);
  endfunction

  function automatic void push_done(int e);
    exp_t x;
    logic [8*ML-1:0] s = '0;
    foreach (pl[i]) s[8*i +: 8] = pl[i];
    good_str = s;
    good_len = 8'(pl.size());
    x.is_done = 1'b1; x.code = 2'd0; x.len = good_len; x.str = good_str; x.at_edge = e;
    sb.push_back(x);
  endfunction

  // Called for every edge at which no byte is strobed.
  function automatic void model_tick(int e);
    if (mode != 0 && e - last_e >= TO) begin
      push_err(2'd2, last_e + TO);
      mode = 0;
    end
  endfunction

  function automatic void model_byte(logic [7:0] b, int e);
    bit a;
    a = (b == 8'h26);
    last_e = e;
    case (mode)
      0: if (a) mode = 1;
      1: begin
        if (a) begin mode = 2; pl.delete(); end
        else mode = 0;
      end
      2: begin
        if (a) mode = 3;
        else if (pl.size() < ML) pl.push_back(b);
        else begin push_err(2'd1, e); mode = 0; end
      end
      default: begin
        if (a) begin
          if (pl.size() == 0) push_err(2'd3, e);
          else push_done(e + 1);
          mode = 0;
        end else if (pl.size() + 2 <= ML) begin
          pl.push_back(8'h26); pl.push_back(b); mode = 2;
        end else begin
          push_err(2'd1, e); mode = 0;
        end
      end
    endcase
  endfunction

  task automatic send(input logic [7:0] b, input int gap);
    for (int i = 1; i < gap; i++) begin
      @(negedge clk); vld = 1'b0; model_tick(edge_n + 1);
    end
    @(negedge clk); data = b; vld = 1'b1; model_byte(b, edge_n + 1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i], 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); vld = 1'b0; model_tick(edge_n + 1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_string"}, 64'(rx_string), 64'd0);
    chk({tag, "_length"}, 64'(rx_length), 64'd0);
    chk({tag, "_done"},   64'(rx_done),   64'd0);
    chk({tag, "_busy"},   64'(rx_busy),   64'd0);
    chk({tag, "_err"},    64'(rx_err),    64'd0);
    chk({tag, "_code"},   64'(rx_err_code), 64'd0);
  endtask

  task automatic model_reset();
    mode = 0; pl.delete(); last_e = 0; good_str = '0; good_len = '0;
  endtask

  // Monitor: every DUT event must match the head of the scoreboard.
  always @(negedge clk) begin : mon
    exp_t x;
    if (rx_done === 1'b1 || rx_err === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_event: got done=%0b err=%0b code=%0d expected none at edge %0d",
                 rx_done, rx_err, rx_err_code, edge_n);
      end else begin
        x = sb.pop_front();
        chk("event_kind", 64'({rx_done, rx_err}), 64'({x.is_done, !x.is_done}));
        chk("event_edge", 64'(edge_n), 64'(x.at_edge));
        chk("rx_length",  64'(rx_length), 64'(x.len));
        chk("rx_string",  64'(rx_string), 64'(x.str));
        if (!x.is_done) begin
          chk("rx_err_code", 64'(rx_err_code), 64'(x.code));
          if (x.code == 2'd2) chk("busy_after_timeout", 64'(rx_busy), 64'd0);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; vld = 1'b0; data = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Normal frame and embedded delimiter, then empty frame.
    send_str("&&AB1&&");  idle(3);
    send_str("&&a&b&&");  idle(3);
    send_str("&&&&");     idle(TO + 5);

    // Overflow at MAX_LEN = 4.
    send_str("&&abcd&&");  idle(3);
    send_str("&&abcde&&"); idle(TO + 5);
    send_str("&&abc&d");   idle(TO + 5);

    // Timeout: expiry, byte exactly at the limit, byte one past it.
    send_str("&&ab"); idle(TO + 5);
    send_str("&&ab"); send(8'h63, TO); send_str("&&"); idle(3);
    send_str("&&a");  send(8'h62, TO + 1); idle(TO + 5);

    // Garbage resync.
    send_str("x&y&&ok&&"); idle(3);

    // Back-to-back frames: next '&' lands in the DONE cycle.
    send_str("&&q&&&&r&&"); idle(3);

    // Randomized stream.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] b;
      int g;
      b = ($urandom_range(0, 9) < 4) ? 8'h26 : 8'(8'h61 + $urandom_range(0, 3));
      g = ($urandom_range(0, 19) == 0) ? int'($urandom_range(TO - 2, TO + 2))
                                       : int'($urandom_range(1, 3));
      send(b, g);
    end
    idle(TO + 5);

    // Reset mid-frame discards the frame silently.
    send_str("&&abc");
    @(negedge clk); vld = 1'b0;
    chk("busy_mid_frame", 64'(rx_busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_reset_outputs("midreset");
    chk("sb_empty_at_reset", 64'(sb.size()), 64'd0);
    send_str("&&z&&"); idle(TO + 5);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
